// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with run/stop control, frame/line markers and pixel-request lead.
// Optional built-in colour-bar source enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned RGB_W       = 12,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned H_DISP      = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned V_DISP      = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned HS_POL      = 0,
  parameter int unsigned VS_POL      = 0,
  parameter int unsigned REQ_LEAD    = 1,
  parameter int unsigned FRAME_CNT_W = 8
) (
  input  logic                   vga_clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   pattern_sel,
  input  logic [RGB_W-1:0]       pixel_data,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_de,
  output logic [RGB_W-1:0]       vga_rgb,
  output logic                   data_req,
  output logic [CNT_W-1:0]       pixel_xpos,
  output logic [CNT_W-1:0]       pixel_ypos,
  output logic                   frame_start,
  output logic                   line_start,
  output logic                   running,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL  = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned XS       = H_SYNC + H_BACK;
  localparam int unsigned YS       = V_SYNC + V_BACK;
  localparam int unsigned XE       = XS + H_DISP;
  localparam int unsigned YE       = YS + V_DISP;
  localparam int unsigned REQ_BEG  = XS - REQ_LEAD;
  localparam int unsigned REQ_END  = XE - REQ_LEAD;
  localparam logic        HS_ACT   = 1'(HS_POL);
  localparam logic        VS_ACT   = 1'(VS_POL);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Elaboration-time parameter sanity checks
  if (REQ_LEAD < 1 || REQ_LEAD > H_BACK) begin : g_bad_lead
    $error("vga_timing_gen: REQ_LEAD must lie in 1..H_BACK");
  end
  if (64'(H_TOTAL) > (64'd1 << CNT_W) || 64'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_bad_width
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt_h;
  logic [CNT_W-1:0]   r_cnt_v;
  logic               w_h_last;
  logic               w_last;

  logic               w_h_act;
  logic               w_v_act;
  logic               w_h_req;
  logic [RGB_W-1:0]   w_pix;

  logic               w_hs;
  logic               w_vs;
  logic               w_de;
  logic               w_req;
  logic [CNT_W-1:0]   w_xpos;
  logic [CNT_W-1:0]   w_ypos;
  logic               w_fs;
  logic               w_ls;
  logic [RGB_W-1:0]   w_rgb;

  logic               r_hs;
  logic               r_vs;
  logic               r_de;
  logic               r_req;
  logic [CNT_W-1:0]   r_xpos;
  logic [CNT_W-1:0]   r_ypos;
  logic               r_fs;
  logic               r_ls;
  logic [RGB_W-1:0]   r_rgb;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  assign w_h_last = (r_cnt_h == H_LAST);
  assign w_last   = w_h_last && (r_cnt_v == V_LAST);

  // State register
  always_ff @(posedge vga_clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: stopping is only honoured at the last position so frames are never truncated
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (en)            w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last && !en) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Raster counters, held at origin while idle
  always_ff @(posedge vga_clk) begin
    if (!rst) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else if (r_state == ST_RUN) begin
      if (w_h_last) begin
        r_cnt_h <= '0;
        r_cnt_v <= (r_cnt_v == V_LAST) ? '0 : r_cnt_v + CNT_W'(1);
      end else begin
        r_cnt_h <= r_cnt_h + CNT_W'(1);
      end
    end else begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end
  end

  assign w_h_act = (r_cnt_h >= CNT_W'(XS))      && (r_cnt_h < CNT_W'(XE));
  assign w_v_act = (r_cnt_v >= CNT_W'(YS))      && (r_cnt_v < CNT_W'(YE));
  assign w_h_req = (r_cnt_h >= CNT_W'(REQ_BEG)) && (r_cnt_h < CNT_W'(REQ_END));

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned C_W  = RGB_W / 3;
  localparam int unsigned PX_W = CNT_W + 3;

  logic [CNT_W-1:0] w_x;
  logic [PX_W-1:0]  w_x8;
  logic [2:0]       w_bar;
  logic [2:0]       w_bar_rgb;
  logic [RGB_W-1:0] w_pat;

  assign w_x  = r_cnt_h - CNT_W'(XS);
  assign w_x8 = {w_x, 3'b000};

  // Bar index = floor(x*8/H_DISP), found by threshold compare instead of a divider
  always_comb begin
    w_bar = 3'd0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (w_x8 >= PX_W'(k * H_DISP)) w_bar = 3'(k);
    end
  end

  always_comb begin
    w_bar_rgb = 3'b000;
    case (w_bar)
      3'd0:    w_bar_rgb = 3'b111;
      3'd1:    w_bar_rgb = 3'b110;
      3'd2:    w_bar_rgb = 3'b011;
      3'd3:    w_bar_rgb = 3'b010;
      3'd4:    w_bar_rgb = 3'b101;
      3'd5:    w_bar_rgb = 3'b100;
      3'd6:    w_bar_rgb = 3'b001;
      default: w_bar_rgb = 3'b000;
    endcase
  end

  assign w_pat = RGB_W'({{C_W{w_bar_rgb[2]}}, {C_W{w_bar_rgb[1]}}, {C_W{w_bar_rgb[0]}}});
  assign w_pix = pattern_sel ? w_pat : pixel_data;
`else
  logic w_unused_pattern_sel;
  assign w_unused_pattern_sel = pattern_sel;
  assign w_pix = pixel_data;
`endif

  // Output decode for the current raster position; idle values outside RUN
  always_comb begin
    w_hs   = ~HS_ACT;
    w_vs   = ~VS_ACT;
    w_de   = 1'b0;
    w_req  = 1'b0;
    w_xpos = '0;
    w_ypos = '0;
    w_fs   = 1'b0;
    w_ls   = 1'b0;
    w_rgb  = '0;
    if (r_state == ST_RUN) begin
      w_hs  = (r_cnt_h < CNT_W'(H_SYNC)) ? HS_ACT : ~HS_ACT;
      w_vs  = (r_cnt_v < CNT_W'(V_SYNC)) ? VS_ACT : ~VS_ACT;
      w_de  = w_h_act && w_v_act;
      w_req = w_h_req && w_v_act;
      if (w_req) begin
        w_xpos = r_cnt_h + CNT_W'(REQ_LEAD) - CNT_W'(XS);
        w_ypos = r_cnt_v - CNT_W'(YS);
      end
      w_ls = (r_cnt_h == '0);
      w_fs = (r_cnt_h == '0) && (r_cnt_v == '0);
      if (w_de) w_rgb = w_pix;
    end
  end

  // Output registers
  always_ff @(posedge vga_clk) begin
    if (!rst) begin
      r_hs   <= ~HS_ACT;
      r_vs   <= ~VS_ACT;
      r_de   <= 1'b0;
      r_req  <= 1'b0;
      r_xpos <= '0;
      r_ypos <= '0;
      r_fs   <= 1'b0;
      r_ls   <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_hs   <= w_hs;
      r_vs   <= w_vs;
      r_de   <= w_de;
      r_req  <= w_req;
      r_xpos <= w_xpos;
      r_ypos <= w_ypos;
      r_fs   <= w_fs;
      r_ls   <= w_ls;
      r_rgb  <= w_rgb;
    end
  end

  // Completed-frame counter, advanced on every wrap from the last position
  always_ff @(posedge vga_clk) begin
    if (!rst) begin
      r_frame_cnt <= '0;
    end else if (r_state == ST_RUN && w_last) begin
      r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_de      = r_de;
  assign vga_rgb     = r_rgb;
  assign data_req    = r_req;
  assign pixel_xpos  = r_xpos;
  assign pixel_ypos  = r_ypos;
  assign frame_start = r_fs;
  assign line_start  = r_ls;
  assign running     = (r_state == ST_RUN);
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster, 3-clock request lead with a 2-cycle-latency source,
// time-based behavioural model checked every cycle, plus literal frame statistics.
module tb_vga_timing_gen;

  localparam int HS  = 4,  HB = 5, HD = 16, HF = 3;
  localparam int VSY = 2,  VB = 3, VD = 6,  VF = 2;
  localparam int HT  = HS + HB + HD + HF;     // 28
  localparam int VT  = VSY + VB + VD + VF;    // 13
  localparam int XS  = HS + HB;
  localparam int YS  = VSY + VB;
  localparam int LEAD = 3;
  localparam int HPOL = 1, VPOL = 0;
  localparam int CW = 8, RW = 12, FCW = 4;

  logic          clk = 1'b0;
  logic          rst, en, pattern_sel;
  logic [RW-1:0] pixel_data;
  logic          vga_hs, vga_vs, vga_de, data_req, frame_start, line_start, running;
  logic [RW-1:0] vga_rgb;
  logic [CW-1:0] pixel_xpos, pixel_ypos;
  logic [FCW-1:0] frame_cnt;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CNT_W(CW), .RGB_W(RW),
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VSY), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .HS_POL(HPOL), .VS_POL(VPOL), .REQ_LEAD(LEAD), .FRAME_CNT_W(FCW)
  ) dut (
    .vga_clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .pixel_data(pixel_data),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb),
    .data_req(data_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .frame_start(frame_start), .line_start(line_start), .running(running), .frame_cnt(frame_cnt)
  );

  // Pixel source with two cycles of latency; junk when not requested
  logic [RW-1:0] s1, s2;
  always @(posedge clk) begin
    s1 <= data_req ? {pixel_ypos[5:0], pixel_xpos[5:0]} : RW'($urandom);
    s2 <= s1;
  end
  assign pixel_data = s2;

  int n_tests = 0, n_fail = 0;

  // Model state: run flag, clocks elapsed since the first counted position, completed frames
  bit m_run = 0;
  int m_t = 0, m_fc = 0;
  logic e_hs, e_vs, e_de, e_req, e_fs, e_ls, e_run;
  logic [CW-1:0] e_x, e_y;
  logic [RW-1:0] e_rgb;
  logic [FCW-1:0] e_fc;

  // Statistics gathered on the DUT outputs
  int cyc = 0, last_fs = -1, per = 0, fr_de = 0, fr_hs = 0, fr_vs = 0;
  int acc_de = 0, acc_hs = 0, acc_vs = 0;
  bit prev_req = 0;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] bar_colour(int bar);
    logic [2:0] c;
    case (bar)
      0: c = 3'b111; 1: c = 3'b110; 2: c = 3'b011; 3: c = 3'b010;
      4: c = 3'b101; 5: c = 3'b100; 6: c = 3'b001; default: c = 3'b000;
    endcase
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction

  task automatic set_idle_exp();
    e_hs = 1'(1 - HPOL); e_vs = 1'(1 - VPOL);
    e_de = 0; e_req = 0; e_fs = 0; e_ls = 0; e_x = '0; e_y = '0; e_rgb = '0;
  endtask

  // Expected outputs after this edge, from inputs as seen at the edge
  task automatic model_step();
    int h, v, x, y, xr;
    if (!rst) begin
      set_idle_exp();
      m_run = 0; m_t = 0; m_fc = 0;
    end else if (!m_run) begin
      set_idle_exp();
      if (en) begin m_run = 1; m_t = 0; end
    end else begin
      h = m_t % HT;
      v = (m_t / HT) % VT;
      x = h - XS;
      y = v - YS;
      xr = h + LEAD - XS;
      e_hs = (h < HS)  ? 1'(HPOL) : 1'(1 - HPOL);
      e_vs = (v < VSY) ? 1'(VPOL) : 1'(1 - VPOL);
      e_de = (x >= 0 && x < HD && y >= 0 && y < VD);
      e_req = (xr >= 0 && xr < HD && y >= 0 && y < VD);
      e_x = e_req ? CW'(xr) : '0;
      e_y = e_req ? CW'(y)  : '0;
      e_fs = (h == 0 && v == 0);
      e_ls = (h == 0);
      e_rgb = '0;
      if (e_de) begin
        e_rgb = {6'(y), 6'(x)};
`ifdef VGA_TEST_PATTERN_EN
        if (pattern_sel) e_rgb = bar_colour((x * 8) / HD);
`endif
      end
      if (h == HT - 1 && v == VT - 1) begin
        m_fc = (m_fc + 1) % (1 << FCW);
        if (!en) m_run = 0;
      end
      m_t++;
    end
    e_run = m_run;
    e_fc = FCW'(m_fc);
  endtask

  task automatic compare();
    logic [38:0] act, exp;
    act = {vga_hs, vga_vs, vga_de, data_req, frame_start, line_start, running, frame_cnt, pixel_xpos, pixel_ypos, vga_rgb};
    exp = {e_hs, e_vs, e_de, e_req, e_fs, e_ls, e_run, e_fc, e_x, e_y, e_rgb};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cycle %0d outputs: got hs/vs/de/req/fs/ls/run=%b%b%b%b%b%b%b fc=%0d x=%0d y=%0d rgb=%h, expected %b%b%b%b%b%b%b fc=%0d x=%0d y=%0d rgb=%h",
               cyc, vga_hs, vga_vs, vga_de, data_req, frame_start, line_start, running, frame_cnt, pixel_xpos, pixel_ypos, vga_rgb,
               e_hs, e_vs, e_de, e_req, e_fs, e_ls, e_run, e_fc, e_x, e_y, e_rgb);
    end
    if (data_req && !prev_req) check("line_first_xpos", int'(pixel_xpos), 0);
    prev_req = data_req;
    if (!running) last_fs = -1;
    if (frame_start) begin
      if (last_fs >= 0) begin
        per = cyc - last_fs; fr_de = acc_de; fr_hs = acc_hs; fr_vs = acc_vs;
      end
      last_fs = cyc;
      acc_de = 0; acc_hs = 0; acc_vs = 0;
    end
    if (vga_de) acc_de++;
    if (vga_hs == 1'(HPOL)) acc_hs++;
    if (vga_vs == 1'(VPOL)) acc_vs++;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_line(int line);
    int n = 0;
    while (!(m_run && ((m_t / HT) % VT) == line) && n < 1000) begin tick(); n++; end
    if (n >= 1000) begin
      n_tests++; n_fail++;
      $display("FAIL wait_line_%0d: timed out after %0d cycles", line, n);
    end
  endtask

  initial begin
    int n, fc_exp;
    rst = 0; en = 0; pattern_sel = 0;
    repeat (3) tick();
    check("rst_running", int'(running), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_hs_idle", int'(vga_hs), 0);
    check("rst_vs_idle", int'(vga_vs), 1);

    // Start and measure whole frames
    rst = 1; en = 1;
    tick();
    check("start_running", int'(running), 1);
    check("start_fs_not_yet", int'(frame_start), 0);
    tick();
    check("start_fs_pulse", int'(frame_start), 1);
    repeat (1100) tick();
    check("frame_period", per, 364);
    check("de_per_frame", fr_de, 96);
    check("hs_per_frame", fr_hs, 52);
    check("vs_per_frame", fr_vs, 56);
    check("frames_done", int'(frame_cnt), 3);

    // Stop request mid-frame: frame completes, then idle
    wait_line(7);
    fc_exp = (m_fc + 1) % (1 << FCW);
    en = 0;
    n = 0;
    while (running && n < 400) begin tick(); n++; end
    check("stop_reached", int'(running), 0);
    check("stop_frame_cnt", int'(frame_cnt), fc_exp);
    repeat (5) tick();
    check("stop_stays_idle", int'(running), 0);
    check("stop_de_idle", int'(vga_de), 0);
    en = 1;
    tick();
    check("restart_running", int'(running), 1);
    tick();
    check("restart_fs", int'(frame_start), 1);

    // Reset mid-frame
    wait_line(9);
    rst = 0;
    tick();
    check("midrst_running", int'(running), 0);
    check("midrst_frame_cnt", int'(frame_cnt), 0);
    check("midrst_rgb", int'(vga_rgb), 0);
    check("midrst_hs", int'(vga_hs), 0);
    rst = 1; en = 1;
    tick();
    tick();
    check("midrst_fs", int'(frame_start), 1);

    // Randomised run/stop/reset/pattern_sel traffic
    for (int i = 0; i < 15000; i++) begin
      rst = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 299) == 0) en = ($urandom_range(0, 3) != 0);
      pattern_sel = 1'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480@60 driver.
- Sits between the pixel clock domain and the pixel source (frame buffer / pattern logic).
- Adds run-time blanking/restart control, configurable sync polarity and pixel-request lead, registered outputs, and frame/line markers.

Parameters:
- CNT_W, 12, width of the h/v counters and of pixel_xpos/pixel_ypos.
- RGB_W, 12, pixel data width.
- H_SYNC, 96, hsync width in clocks.
- H_BACK, 48, h back porch.
- H_DISP, 640, active pixels per line.
- H_FRONT, 16, h front porch.
- V_SYNC, 2, vsync width in lines.
- V_BACK, 33, v back porch.
- V_DISP, 480, active lines.
- V_FRONT, 10, v front porch.
- HS_POL, 0, hsync active level.
- VS_POL, 0, vsync active level.
- REQ_LEAD, 1, clocks data_req leads display enable; legal range 1..H_BACK.
- FRAME_CNT_W, 8, frame counter width.

Ports:
- vga_clk, in, 1, pixel clock.
- rst, in, 1, reset, synchronous, active-low.
- en, in, 1, run enable.
- pattern_sel, in, 1, selects the built-in pattern (used only with the optional feature).
- pixel_data, in, RGB_W, pixel colour from the source.
- vga_hs, out, 1, horizontal sync.
- vga_vs, out, 1, vertical sync.
- vga_de, out, 1, display enable.
- vga_rgb, out, RGB_W, colour output.
- data_req, out, 1, pixel request.
- pixel_xpos, out, CNT_W, requested x coordinate.
- pixel_ypos, out, CNT_W, requested y coordinate.
- frame_start, out, 1, one-clock pulse at the start of a frame.
- line_start, out, 1, one-clock pulse at the start of each line.
- running, out, 1, generator active.
- frame_cnt, out, FRAME_CNT_W, completed-frame count.

Behaviour:
- Derived totals: H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL likewise. XS = H_SYNC+H_BACK; YS = V_SYNC+V_BACK.
- Reset (rst low at a vga_clk edge): cnt_h=cnt_v=0, running=0, frame_cnt=0.
  - Reset values: vga_hs=~HS_POL, vga_vs=~VS_POL; vga_de, data_req, frame_start, line_start = 0; vga_rgb, pixel_xpos, pixel_ypos = 0.
  - Reset overrides everything, including a frame in progress.
- State is implied by running: IDLE (running=0) and RUN (running=1).
  - IDLE: counters held at 0; all outputs at their reset values.
  - IDLE->RUN: on an edge with en=1. running=1 and counting starts from (0,0) at that edge.
  - RUN->IDLE: only at an edge where (cnt_h,cnt_v)=(H_TOTAL-1,V_TOTAL-1) and en=0. en low mid-frame is ignored until the frame ends, so frames are never truncated.
  - If en=1 at the last position, the frame wraps to (0,0) and continues.
- Counting in RUN:
  - cnt_h wraps H_TOTAL-1 -> 0.
  - cnt_v increments when cnt_h=H_TOTAL-1 and wraps V_TOTAL-1 -> 0.
  - frame_cnt increments (modulo 2^FRAME_CNT_W) when the counter wraps from (H_TOTAL-1,V_TOTAL-1).
- Output timing: all outputs are registered. In the cycle after the counter holds (h,v):
  - vga_hs = HS_POL iff h<H_SYNC.
  - vga_vs = VS_POL iff v<V_SYNC.
  - vga_de = 1 iff XS<=h<XS+H_DISP and YS<=v<YS+V_DISP.
  - vga_rgb = vga_de ? pixel_data (sampled at that edge) : 0.
  - frame_start = (h,v)==(0,0).
  - line_start = h==0.
- Pixel request:
  - data_req = 1 iff XS-REQ_LEAD<=h<XS+H_DISP-REQ_LEAD and YS<=v<YS+V_DISP.
  - When data_req=1: pixel_xpos = h+REQ_LEAD-XS (0..H_DISP-1) and pixel_ypos = v-YS (0..V_DISP-1). Otherwise both are 0.
- Source contract: pixel_data for a coordinate must be valid REQ_LEAD-1 clocks after the cycle in which data_req presents that coordinate. REQ_LEAD=1 requires a combinational source.
- Arithmetic: all comparisons are unsigned, at CNT_W bits. H_TOTAL and V_TOTAL must be <= 2^CNT_W.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: when pattern_sel=1, active pixels show 8 vertical colour bars and pixel_data is ignored.
  - Bar index = (x*8)/H_DISP, where x = h-XS.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black. Each colour's R/G/B third of RGB_W is all-ones or all-zeros.
  - data_req, pixel_xpos and pixel_ypos still run normally.
  - pattern_sel is sampled every clock.
- Undefined: pattern_sel is ignored; no pattern logic is synthesised.

Test Plan:
- Default parameters, en=1 after reset -> frame_start pulses every 420000 clocks; vga_hs low 96 clocks per 800; vga_vs low 1600 clocks per frame; 307200 vga_de cycles per frame.
- REQ_LEAD=3, source with 2-cycle latency returning {ypos[5:0],xpos[5:0]} -> every vga_de cycle at pixel (x,y) shows vga_rgb={y[5:0],x[5:0]}; the first data_req of each line shows pixel_xpos=0.
- en dropped at mid-frame line 200 -> counting continues to (799,524), then running=0, outputs idle; frame_cnt increments once. Re-asserting en -> frame_start pulse 1 clock later.
- rst low at line 300 -> at the next edge all outputs take their reset values and frame_cnt=0; after release with en=1 the first frame_start pulse is 1 clock later.
- HS_POL=1, VS_POL=1, H_DISP=800/V_DISP=600 timings (40/88/800/40, 4/23/600/1) -> positive-going syncs; 480000 de cycles per frame.
- With VGA_TEST_PATTERN_EN, RGB_W=12, pattern_sel=1 -> x=0 gives 12'hFFF, x=85 gives 12'hFF0, x=639 gives 12'h000.
